// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational 32-bit ALU.
// One operation in flight: accept, one execute cycle, then hold the response until it is taken.
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_in1,
    input  logic [DATA_W-1:0] req0_in2,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_in1,
    input  logic [DATA_W-1:0] req1_in2,
    input  logic [CTRL_W-1:0] req1_ctrl,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_zero,
    output logic              rsp_illegal,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              last_grant;
    logic [DATA_W-1:0] op_in1;
    logic [DATA_W-1:0] op_in2;
    logic [CTRL_W-1:0] op_ctrl;
    logic              op_id;
    logic              accept;
    logic              grant_id;
    logic              illegal;

    assign alu_in1  = op_in1;
    assign alu_in2  = op_in2;
    assign alu_ctrl = op_ctrl;

    // Legal codes: AND, OR, ADD, SUB.
    assign illegal = !((op_ctrl == CTRL_W'(0)) || (op_ctrl == CTRL_W'(1)) ||
                       (op_ctrl == CTRL_W'(2)) || (op_ctrl == CTRL_W'(6)));

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        state_next = state;
        case (state)
            IDLE: begin
                // With both pending, the requester not served last wins.
                req0_ready = req0_valid && (!req1_valid || last_grant);
                req1_ready = req1_valid && (!req0_valid || !last_grant);
                if (req0_ready || req1_ready) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign accept   = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign grant_id = req1_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            op_in1      <= '0;
            op_in2      <= '0;
            op_ctrl     <= '0;
            op_id       <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_data    <= '0;
            rsp_zero    <= 1'b0;
            rsp_illegal <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state     <= state_next;
            busy      <= (state_next != IDLE);
            rsp_valid <= (state_next == RESP);
            if (accept) begin
                last_grant <= grant_id;
                op_id      <= grant_id;
                op_in1     <= grant_id ? req1_in1  : req0_in1;
                op_in2     <= grant_id ? req1_in2  : req0_in2;
                op_ctrl    <= grant_id ? req1_ctrl : req0_ctrl;
            end
            if (state == EXEC) begin
                rsp_data    <= alu_result;
                rsp_zero    <= alu_zero;
                rsp_illegal <= illegal;
                rsp_id      <= op_id;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic checked against a
// transaction-level model (one outstanding op, response due two cycles after accept).
module tb_alu_arbiter;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [DW-1:0] req0_in1, req0_in2, req1_in1, req1_in2;
    logic [CW-1:0] req0_ctrl, req1_ctrl;
    logic [DW-1:0] alu_in1, alu_in2, alu_result;
    logic [CW-1:0] alu_ctrl;
    logic          alu_zero;
    logic          rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_illegal, busy;
    logic [DW-1:0] rsp_data;

    alu_arbiter #(.DATA_W(DW), .CTRL_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_ctrl(req1_ctrl),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Returns {zero, result}; unsupported codes yield result 0 with zero flag 0.
    function automatic logic [DW:0] ref_alu(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [CW-1:0] c);
        logic [DW-1:0] r;
        case (c)
            4'd0:    r = a & b;
            4'd1:    r = a | b;
            4'd2:    r = a + b;
            4'd6:    r = a - b;
            default: return {1'b0, {DW{1'b0}}};
        endcase
        return {(r == 0), r};
    endfunction

    function automatic bit is_illegal(input logic [CW-1:0] c);
        return !(c == 4'd0 || c == 4'd1 || c == 4'd2 || c == 4'd6);
    endfunction

    logic [DW:0] env_alu;
    always_comb begin
        env_alu    = ref_alu(alu_in1, alu_in2, alu_ctrl);
        alu_result = env_alu[DW-1:0];
        alu_zero   = env_alu[DW];
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Transaction-level model state
    bit            m_out;
    int            m_acc_cyc;
    bit            m_last;
    bit            m_id;
    logic [DW-1:0] m_in1, m_in2;
    logic [CW-1:0] m_ctrl;
    int            cyc;
    bit            track;
    int            acc_cyc_q[$];
    bit            acc_id_q[$];

    task automatic drive(input bit v0, input bit v1,
                         input logic [DW-1:0] a0, input logic [DW-1:0] b0, input logic [CW-1:0] c0,
                         input logic [DW-1:0] a1, input logic [DW-1:0] b1, input logic [CW-1:0] c1,
                         input bit rr);
        req0_valid = v0; req1_valid = v1;
        req0_in1 = a0; req0_in2 = b0; req0_ctrl = c0;
        req1_in1 = a1; req1_in2 = b1; req1_ctrl = c1;
        rsp_ready = rr;
    endtask

    // Called just after a falling edge with inputs already driven; returns at the next falling edge.
    task automatic step();
        bit          er0, er1, erv;
        logic [DW:0] res;
        #1;
        er0 = !m_out && req0_valid && (!req1_valid || m_last);
        er1 = !m_out && req1_valid && (!req0_valid || !m_last);
        erv = m_out && (cyc >= m_acc_cyc + 2);
        check("req0_ready", 32'(req0_ready), 32'(er0));
        check("req1_ready", 32'(req1_ready), 32'(er1));
        check("busy", 32'(busy), 32'(m_out));
        check("rsp_valid", 32'(rsp_valid), 32'(erv));
        if (m_out && cyc == m_acc_cyc + 1) begin
            check("alu_in1", alu_in1, m_in1);
            check("alu_in2", alu_in2, m_in2);
            check("alu_ctrl", 32'(alu_ctrl), 32'(m_ctrl));
        end
        if (erv) begin
            res = ref_alu(m_in1, m_in2, m_ctrl);
            check("rsp_data", rsp_data, res[DW-1:0]);
            check("rsp_zero", 32'(rsp_zero), 32'(res[DW]));
            check("rsp_illegal", 32'(rsp_illegal), 32'(is_illegal(m_ctrl)));
            check("rsp_id", 32'(rsp_id), 32'(m_id));
        end
        if (track && ((req0_valid && req0_ready) || (req1_valid && req1_ready))) begin
            acc_cyc_q.push_back(cyc);
            acc_id_q.push_back(req1_ready);
        end
        if (erv && rsp_ready) begin
            m_out = 1'b0;
        end else if (er0 || er1) begin
            m_out = 1'b1; m_acc_cyc = cyc; m_id = er1; m_last = er1;
            m_in1 = er1 ? req1_in1 : req0_in1;
            m_in2 = er1 ? req1_in2 : req0_in2;
            m_ctrl = er1 ? req1_ctrl : req0_ctrl;
        end
        @(negedge clk);
        cyc++;
    endtask

    // Reset asserted for one cycle from a falling edge; outputs must clear immediately.
    task automatic pulse_reset();
        rst_n = 1'b0;
        drive(0, 0, '0, '0, '0, '0, '0, '0, 1);
        #1;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_rsp_data", rsp_data, 32'(0));
        check("rst_rsp_flags", {29'(0), rsp_zero, rsp_illegal, rsp_id}, 32'(0));
        check("rst_alu_in1", alu_in1, 32'(0));
        check("rst_alu_ctrl", 32'(alu_ctrl), 32'(0));
        m_out = 1'b0; m_last = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        cyc++;
    endtask

    logic [CW-1:0] legal_codes [4] = '{4'd0, 4'd1, 4'd2, 4'd6};

    function automatic logic [CW-1:0] rand_ctrl();
        if ($urandom_range(0, 4) == 0) return CW'($urandom_range(0, 15));
        return legal_codes[$urandom_range(0, 3)];
    endfunction

    initial begin
        logic [DW-1:0] a, b, held;
        cyc = 0; track = 1'b0; m_out = 1'b0; m_last = 1'b1; m_acc_cyc = 0;
        rst_n = 1'b1;
        drive(0, 0, '0, '0, '0, '0, '0, '0, 1);
        @(negedge clk);
        pulse_reset();

        // Single add from requester 0
        drive(1, 0, 32'd5, 32'd3, 4'b0010, '0, '0, '0, 1);
        step();
        drive(0, 0, '0, '0, '0, '0, '0, '0, 1);
        step();
        #1;
        check("add_valid_n2", 32'(rsp_valid), 32'(1));
        check("add_data", rsp_data, 32'd8);
        step();
        step();

        // Subtract equal operands from requester 1
        drive(0, 1, '0, '0, '0, 32'h1234, 32'h1234, 4'b0110, 1);
        step();
        drive(0, 0, '0, '0, '0, '0, '0, '0, 1);
        step();
        #1;
        check("sub_zero", 32'(rsp_zero), 32'(1));
        check("sub_id", 32'(rsp_id), 32'(1));
        step();
        step();

        // Illegal code
        drive(1, 0, 32'd7, 32'd9, 4'b1111, '0, '0, '0, 1);
        step();
        drive(0, 0, '0, '0, '0, '0, '0, '0, 1);
        step();
        #1;
        check("ill_flag", 32'(rsp_illegal), 32'(1));
        check("ill_data", rsp_data, 32'd0);
        step();
        step();

        // Backpressure: response held four cycles while both requesters wait
        drive(1, 1, 32'd100, 32'd58, 4'b0110, 32'd1, 32'd2, 4'b0010, 0);
        step();
        step();
        #1;
        held = rsp_data;
        step();
        for (int i = 0; i < 3; i++) step();
        check("bp_held", rsp_data, held);
        rsp_ready = 1'b1;
        step();
        step();
        drive(0, 0, '0, '0, '0, '0, '0, '0, 1);
        for (int i = 0; i < 4; i++) step();

        // Reset during EXEC discards the operation; next both-valid grant goes to 0
        drive(0, 1, 32'd9, 32'd9, 4'b0010, 32'd4, 32'd4, 4'b0010, 1);
        step();
        pulse_reset();
        drive(0, 0, '0, '0, '0, '0, '0, '0, 1);
        for (int i = 0; i < 3; i++) step();

        // Contention: both valid continuously after reset
        track = 1'b1;
        for (int i = 0; i < 24; i++) begin
            drive(1, 1, $urandom, $urandom, rand_ctrl(), $urandom, $urandom, rand_ctrl(), 1);
            step();
        end
        track = 1'b0;
        check("cont_count", 32'(acc_id_q.size()), 32'd8);
        for (int k = 0; k < acc_id_q.size(); k++) begin
            check("cont_order", 32'(acc_id_q[k]), 32'(k % 2));
            if (k >= 2) check("cont_period", 32'(acc_cyc_q[k] - acc_cyc_q[k-2]), 32'd6);
        end
        drive(0, 0, '0, '0, '0, '0, '0, '0, 1);
        for (int i = 0; i < 4; i++) step();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? a : $urandom;
            drive($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                  a, b, rand_ctrl(), $urandom, ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom,
                  rand_ctrl(), $urandom_range(0, 3) != 0);
            if (i == 300) pulse_reset();
            else step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width; SHALL equal 32 (ALU is fixed 32-bit).
REQ-002 Parameter CTRL_W, default 4, ALU control code width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req0_valid / req1_valid  input  1  requester N has an operation pending.
REQ-006 req0_ready / req1_ready  output  1  arbiter accepts requester N this cycle.
REQ-007 req0_in1, req0_in2 / req1_in1, req1_in2  input  DATA_W  operands of requester N.
REQ-008 req0_ctrl / req1_ctrl  input  CTRL_W  ALU control code of requester N.
REQ-009 alu_in1, alu_in2  output  DATA_W  operands driven to shared ALU.
REQ-010 alu_ctrl  output  CTRL_W  control code driven to shared ALU.
REQ-011 alu_result  input  DATA_W  combinational ALU result.
REQ-012 alu_zero  input  1  combinational ALU zero flag.
REQ-013 rsp_valid  output  1  response held for consumer.
REQ-014 rsp_ready  input  1  consumer takes response.
REQ-015 rsp_id  output  1  requester index owning the response.
REQ-016 rsp_data  output  DATA_W  captured ALU result.
REQ-017 rsp_zero  output  1  captured zero flag.
REQ-018 rsp_illegal  output  1  captured ctrl not in {0000,0001,0010,0110}.
REQ-019 busy  output  1  high whenever state is not IDLE.

Function
REQ-020 FSM states SHALL be IDLE, EXEC, RESP; one operation outstanding at a time.
REQ-021 IDLE: at most one reqN_ready high, chosen by round-robin grant; in EXEC/RESP both readys SHALL be 0.
REQ-022 Grant: both valid -> requester other than last_grant; one valid -> that one; none -> no ready.
REQ-023 last_grant SHALL update to the accepted index on each accept (valid & ready).
REQ-024 Accept SHALL latch in1, in2, ctrl, id into internal registers and move IDLE -> EXEC.
REQ-025 alu_in1/alu_in2/alu_ctrl SHALL be driven only from latched registers, never directly from request inputs.
REQ-026 EXEC lasts exactly one cycle; at its end alu_result, alu_zero, illegal flag captured into rsp_* registers; EXEC -> RESP.
REQ-027 RESP: rsp_valid=1; rsp_data/rsp_zero/rsp_illegal/rsp_id SHALL stay stable until rsp_valid & rsp_ready.
REQ-028 RESP with rsp_ready=1 -> IDLE next cycle; rsp_ready=0 -> remain RESP (backpressure, no drop).
REQ-029 Latency: accept in cycle N -> rsp_valid first high in cycle N+2; minimum issue interval 3 cycles.
REQ-030 rsp_ready while not in RESP SHALL be ignored.
REQ-031 reqN_valid deasserting while not granted SHALL be legal; no state change.
REQ-032 Illegal ctrl SHALL still be sequenced normally; rsp_data = alu_result (0), rsp_zero = alu_zero, rsp_illegal = 1.
REQ-033 rsp_valid and busy SHALL be registered outputs; reqN_ready combinational from state, valids, last_grant.

Reset
REQ-034 rst_n low SHALL asynchronously force: state IDLE, last_grant=1, rsp_valid=0, rsp_data=0, rsp_zero=0, rsp_illegal=0, rsp_id=0, busy=0, latched operands/ctrl=0.
REQ-035 Reset mid-operation (EXEC or RESP) SHALL discard the operation; no response after release.
REQ-036 After release, first grant with both valid SHALL go to requester 0.

Verification
REQ-037 Single op: req0 in1=5, in2=3, ctrl=0010, rsp_ready=1 -> rsp_valid at N+2, rsp_data=8, rsp_zero=0, rsp_id=0, rsp_illegal=0.
REQ-038 Subtract equal: req1 in1=in2=0x1234, ctrl=0110 -> rsp_data=0, rsp_zero=1, rsp_id=1.
REQ-039 Contention: both valid continuously after reset -> accepts alternate 0,1,0,1; each requester served every 6 cycles with rsp_ready=1.
REQ-040 Backpressure: rsp_ready=0 for 4 cycles in RESP -> rsp_valid and rsp_data stable, both readys 0, no new accept until handshake.
REQ-041 Illegal op: ctrl=1111, in1=7, in2=9 -> rsp_data=0, rsp_zero=0, rsp_illegal=1.
REQ-042 Reset in EXEC: assert rst_n low 1 cycle -> busy=0 and rsp_valid=0 immediately, no response emitted; next both-valid grant to requester 0.
